// File: rtl/counter_arbiter_pkg.sv
// Shared types for the counter arbiter: counter opcodes and arbiter FSM states.
package counter_arb_pkg;

  typedef enum logic [1:0] {OP_NOP, OP_UP, OP_DOWN, OP_LOAD} cnt_op_e;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_COMPLETE} arb_state_e;

endpackage

// File: rtl/counter_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins, wrapping N-1 -> 0.
module rr_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          valid
);

  int          j_s;
  logic [IW-1:0] jx_s;

  // Scan requesters in priority order starting at ptr
  always_comb begin
    grant = {N{1'b0}};
    idx   = {IW{1'b0}};
    valid = 1'b0;
    j_s   = 0;
    jx_s  = {IW{1'b0}};
    for (int i = 0; i < N; i++) begin
      j_s = int'(ptr) + i;
      if (j_s >= N) begin
        j_s = j_s - N;
      end else begin
        j_s = j_s;
      end
      jx_s = IW'(j_s);
      if (!valid && req[jx_s]) begin
        valid       = 1'b1;
        grant[jx_s] = 1'b1;
        idx         = jx_s;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin front end that shares one up/down/load counter among N requesters,
// issuing one registered command per grant and returning the post-update count with ack.
module counter_arbiter
  import counter_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           srst,
  input  logic [N-1:0]   req,
  input  logic [2*N-1:0] op,
  input  logic [W*N-1:0] wdata,
  output logic [N-1:0]   ack,
  output logic [W-1:0]   rsp_count,
  output logic           rsp_roll,
  output logic           busy,
  output logic           cnt_load,
  output logic           cnt_up,
  output logic           cnt_down,
  output logic [W-1:0]   cnt_data,
  input  logic [W-1:0]   cnt_count,
  input  logic           cnt_rollover
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] win_idx_q, win_idx_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [W-1:0]  rsp_count_q, rsp_count_d;
  logic          rsp_roll_q, rsp_roll_d;
  logic          busy_q, busy_d;
  logic          cnt_load_q, cnt_load_d;
  logic          cnt_up_q, cnt_up_d;
  logic          cnt_down_q, cnt_down_d;
  logic [W-1:0]  cnt_data_q, cnt_data_d;

  logic [N-1:0]  gnt_s;
  logic [IW-1:0] gnt_idx_s;
  logic          gnt_valid_s;
  logic [1:0]    op_arr_s    [N];
  logic [W-1:0]  wdata_arr_s [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign op_arr_s[g]    = op[2*g +: 2];
    assign wdata_arr_s[g] = wdata[W*g +: W];
  end

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .grant (gnt_s),
    .idx   (gnt_idx_s),
    .valid (gnt_valid_s)
  );

  // Next-state and registered-output computation; command strobes act as the op/wdata latch
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_idx_d   = win_idx_q;
    ack_d       = {N{1'b0}};
    rsp_count_d = {W{1'b0}};
    rsp_roll_d  = 1'b0;
    cnt_load_d  = 1'b0;
    cnt_up_d    = 1'b0;
    cnt_down_d  = 1'b0;
    cnt_data_d  = {W{1'b0}};
    case (state_q)
      S_IDLE: begin
        if (gnt_valid_s) begin
          state_d   = S_ISSUE;
          win_idx_d = gnt_idx_s;
          case (cnt_op_e'(op_arr_s[gnt_idx_s]))
            OP_UP:   cnt_up_d   = 1'b1;
            OP_DOWN: cnt_down_d = 1'b1;
            OP_LOAD: begin
              cnt_load_d = 1'b1;
              cnt_data_d = wdata_arr_s[gnt_idx_s];
            end
            default: cnt_load_d = 1'b0;
          endcase
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: state_d = S_COMPLETE;
      S_COMPLETE: begin
        state_d            = S_IDLE;
        ack_d[win_idx_q]   = 1'b1;
        rsp_count_d        = cnt_count;
        rsp_roll_d         = cnt_rollover;
        if (win_idx_q == IW'(N - 1)) begin
          ptr_d = {IW{1'b0}};
        end else begin
          ptr_d = win_idx_q + {{(IW-1){1'b0}}, 1'b1};
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q     <= S_IDLE;
      ptr_q       <= {IW{1'b0}};
      win_idx_q   <= {IW{1'b0}};
      ack_q       <= {N{1'b0}};
      rsp_count_q <= {W{1'b0}};
      rsp_roll_q  <= 1'b0;
      busy_q      <= 1'b0;
      cnt_load_q  <= 1'b0;
      cnt_up_q    <= 1'b0;
      cnt_down_q  <= 1'b0;
      cnt_data_q  <= {W{1'b0}};
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_idx_q   <= win_idx_d;
      ack_q       <= ack_d;
      rsp_count_q <= rsp_count_d;
      rsp_roll_q  <= rsp_roll_d;
      busy_q      <= busy_d;
      cnt_load_q  <= cnt_load_d;
      cnt_up_q    <= cnt_up_d;
      cnt_down_q  <= cnt_down_d;
      cnt_data_q  <= cnt_data_d;
    end
  end

  assign ack       = ack_q;
  assign rsp_count = rsp_count_q;
  assign rsp_roll  = rsp_roll_q;
  assign busy      = busy_q;
  assign cnt_load  = cnt_load_q;
  assign cnt_up    = cnt_up_q;
  assign cnt_down  = cnt_down_q;
  assign cnt_data  = cnt_data_q;

endmodule
